// File: rtl/tetris_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tetris_ctrl                                                   |
// | Purpose  : Game-flow controller for a falling-block game. Sequences the  |
// |            spawn / move / land / clear cycle, turns button presses into  |
// |            one-shot move requests, runs the gravity timer, commits the   |
// |            datapath's candidate board/location/rotation and keeps score. |
// | Ports    : clka, restart_n (async, active-low)                           |
// |            btn_left/btn_right/btn_rotate - level buttons                 |
// |            new_game - restart request (GAMEOVER only)                    |
// |            touched, error, piece_in, location_in, rotation_in, board_in  |
// |              - status and candidate values from the datapath             |
// |            state, move, board_q, location_q, rotation_q, piece_q, score, |
// |            game_over - registered (or state-decoded) outputs             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tetris_ctrl #(
  parameter logic [23:0] DROP_TICKS = 24'd1_000_000,
  parameter int unsigned SCORE_W    = 8
) (
  input  logic               clka,
  input  logic               restart_n,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_rotate,
  input  logic               new_game,
  input  logic               touched,
  input  logic               error,
  input  logic [1:0]         piece_in,
  input  logic [4:0]         location_in,
  input  logic [1:0]         rotation_in,
  input  logic [31:0]        board_in,
  output logic [2:0]         state,
  output logic [1:0]         move,
  output logic [31:0]        board_q,
  output logic [4:0]         location_q,
  output logic [1:0]         rotation_q,
  output logic [1:0]         piece_q,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  typedef enum logic [2:0] {
    ST_GEN      = 3'b000,
    ST_MOVE     = 3'b001,
    ST_LAND     = 3'b010,
    ST_CLEAR    = 3'b011,
    ST_NEWBOARD = 3'b100,
    ST_GAMEOVER = 3'b101
  } state_e;

  localparam logic [1:0]         MV_NONE   = 2'd0;
  localparam logic [1:0]         MV_LEFT   = 2'd1;
  localparam logic [1:0]         MV_RIGHT  = 2'd2;
  localparam logic [1:0]         MV_ROTATE = 2'd3;
  localparam logic [4:0]         LOC_HOME  = 5'd2;
  localparam logic [23:0]        TICK_LAST = DROP_TICKS - 24'd1;
  localparam logic [SCORE_W+3:0] SCORE_MAX = {4'b0000, {SCORE_W{1'b1}}};

  state_e             state_q, state_d;
  logic [1:0]         pend_q, pend_d;      // 0 doubles as "empty"
  logic [2:0]         hist_q, hist_d;      // {rotate, right, left}
  logic [23:0]        cnt_q, cnt_d;
  logic [31:0]        board_d;
  logic [4:0]         location_d;
  logic [1:0]         rotation_d, piece_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic [2:0]         btn_now, rise;
  logic [1:0]         edge_code;
  logic               tick;
  logic [3:0]         full_rows;
  logic [SCORE_W+3:0] score_sum;

  assign btn_now = {btn_rotate, btn_right, btn_left};
  assign rise    = btn_now & ~hist_q;
  // Rotate wins over left, left over right when edges coincide.
  assign edge_code = rise[2] ? MV_ROTATE :
                     rise[0] ? MV_LEFT   :
                     rise[1] ? MV_RIGHT  : MV_NONE;
  assign tick = (cnt_q == TICK_LAST);

  always_comb begin
    full_rows = 4'd0;
    for (int r = 0; r < 8; r++) begin
      if (board_q[4*r +: 4] == 4'hF) full_rows = full_rows + 4'd1;
    end
  end

  assign score_sum = {4'b0000, score_q} + {{SCORE_W{1'b0}}, full_rows};

  always_comb begin
    state_d    = state_q;
    hist_d     = btn_now;
    // Pending register only accepts a new code while empty.
    pend_d     = (pend_q == MV_NONE) ? edge_code : pend_q;
    cnt_d      = cnt_q;
    board_d    = board_q;
    location_d = location_q;
    rotation_d = rotation_q;
    piece_d    = piece_q;
    score_d    = score_q;

    case (state_q)
      ST_NEWBOARD: begin
        board_d    = 32'd0;
        location_d = LOC_HOME;
        rotation_d = 2'd0;
        piece_d    = 2'd0;
        score_d    = '0;
        cnt_d      = 24'd0;
        pend_d     = MV_NONE;
        state_d    = ST_GEN;
      end
      ST_GEN: begin
        piece_d = piece_in;
        cnt_d   = 24'd0;
        state_d = ST_MOVE;
      end
      ST_MOVE: begin
        cnt_d = tick ? 24'd0 : cnt_q + 24'd1;
        if (pend_q != MV_NONE || tick) begin
          board_d    = board_in;
          location_d = location_in;
          rotation_d = rotation_in;
        end
        // The code being presented this cycle is consumed; any edge seen
        // now arrives while the register is still full and is dropped.
        if (pend_q != MV_NONE) pend_d = MV_NONE;
        if (touched) begin
          pend_d  = MV_NONE;
          state_d = ST_LAND;
        end
      end
      ST_LAND: begin
        score_d = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        board_d = board_in;
        state_d = error ? ST_GAMEOVER : ST_GEN;
      end
      ST_GAMEOVER: begin
        pend_d = MV_NONE;
        if (new_game) state_d = ST_NEWBOARD;
      end
      default: begin
        pend_d  = MV_NONE;
        state_d = ST_NEWBOARD;
      end
    endcase
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q    <= ST_NEWBOARD;
      pend_q     <= MV_NONE;
      hist_q     <= 3'd0;
      cnt_q      <= 24'd0;
      board_q    <= 32'd0;
      location_q <= LOC_HOME;
      rotation_q <= 2'd0;
      piece_q    <= 2'd0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      hist_q     <= hist_d;
      cnt_q      <= cnt_d;
      board_q    <= board_d;
      location_q <= location_d;
      rotation_q <= rotation_d;
      piece_q    <= piece_d;
      score_q    <= score_d;
    end
  end

  assign state     = state_q;
  assign move      = (state_q == ST_MOVE) ? pend_q : MV_NONE;
  assign game_over = (state_q == ST_GAMEOVER);
  assign score     = score_q;

endmodule
`default_nettype wire

// File: doc/tetris_ctrl.md
TETRIS_CTRL -- requirements
Module: tetris_ctrl

Interface
REQ-001 Parameter: DROP_TICKS, 24'd1_000_000, clka cycles between gravity steps; legal range 2 to 2^24-1.
REQ-002 Parameter: SCORE_W, 8, score counter width.
REQ-003 clka  in  1  sole clock; all state changes on posedge clka.
REQ-004 restart_n  in  1  reset, asynchronous assert, active-low.
REQ-005 btn_left, btn_right, btn_rotate  in  1 each  player buttons, synchronous to clka, level.
REQ-006 new_game  in  1  restart request, honoured only in GAMEOVER.
REQ-007 touched  in  1  datapath: active piece has landed.
REQ-008 error  in  1  datapath: spawn collision.
REQ-009 piece_in  in  2  datapath: generated piece type.
REQ-010 location_in  in  5  datapath: candidate location.
REQ-011 rotation_in  in  2  datapath: candidate rotation.
REQ-012 board_in  in  32  datapath: candidate board; row r = bits [4r+3:4r], r = 0..7.
REQ-013 state  out  3  FSM state to datapath.
REQ-014 move  out  2  0 = none, 1 = left, 2 = right, 3 = rotate.
REQ-015 board_q  out  32  committed board.
REQ-016 location_q  out  5  committed location.
REQ-017 rotation_q  out  2  committed rotation.
REQ-018 piece_q  out  2  committed piece type.
REQ-019 score  out  SCORE_W  cleared-row count.
REQ-020 game_over  out  1  high exactly while state = GAMEOVER.

Function
REQ-021 State encoding: GEN 000, MOVE 001, LAND 010, CLEAR 011, NEWBOARD 100, GAMEOVER 101; 110/111 -> NEWBOARD next cycle.
REQ-022 NEWBOARD: lasts 1 cycle; board_q = 0, location_q = 5'd2, rotation_q = 0, piece_q = 0, score = 0, drop counter = 0, pending move cleared; next GEN.
REQ-023 GEN: lasts 1 cycle; piece_q <= piece_in; next MOVE.
REQ-024 Button edge detect: one-cycle registered history per button; rising edge = current high and previous low.
REQ-025 Pending move: 1-entry register; on an edge while empty, load the code; simultaneous edges -> rotate > left > right; edges while full are dropped.
REQ-026 MOVE: move output = pending code for exactly one cycle, then the pending register clears that same cycle; move = 0 in every other state.
REQ-027 Drop counter: counts 0..DROP_TICKS-1 only in MOVE, wraps to 0; tick = (count == DROP_TICKS-1); the counter is held in all other states and cleared on GEN.
REQ-028 Commit in MOVE: when move != 0 or tick, board_q, location_q and rotation_q <= board_in, location_in and rotation_in on the same edge; no commit otherwise.
REQ-029 touched sampled only in MOVE: if high, go to LAND next cycle; any commit enabled in that cycle still occurs; a pending move is discarded.
REQ-030 LAND: lasts 1 cycle; score += number of rows of board_q equal to 4'hF (0..8); saturates at 2^SCORE_W-1; next CLEAR.
REQ-031 CLEAR: lasts 1 cycle; board_q <= board_in; error high -> GAMEOVER, else GEN.
REQ-032 GAMEOVER: all registers held; move = 0; buttons ignored and pending cleared; new_game high -> NEWBOARD next cycle.
REQ-033 touched and error are ignored outside MOVE and CLEAR respectively; new_game is ignored outside GAMEOVER.
REQ-034 All outputs are registered or decoded from registered state only, with no combinational input-to-output paths.

Reset
REQ-035 restart_n low asynchronously forces: state = NEWBOARD, move = 0, board_q = 0, location_q = 5'd2, rotation_q = 0, piece_q = 0, score = 0, game_over = 0, drop counter = 0, pending empty, button history = 0.
REQ-036 Reset asserted mid-MOVE or mid-LAND discards all progress; after release the first edge executes NEWBOARD, then GEN.
REQ-037 Buttons held high through reset release produce no edge.

Verification
REQ-038 Reset release, piece_in = 2 -> NEWBOARD, GEN, MOVE on successive cycles; piece_q = 2 after GEN.
REQ-039 DROP_TICKS = 4, no buttons, board_in = 32'h0000_0010 -> commit every 4th MOVE cycle; board_q = 32'h10 after first tick.
REQ-040 btn_left and btn_rotate rise on the same cycle -> single move = 3 pulse of 1 cycle; left is lost; a further edge while pending is dropped.
REQ-041 touched in MOVE with board_q rows 0 and 1 = 4'hF -> LAND, then score = 2, CLEAR, GEN; score starting at 254 with 3 full rows -> 255.
REQ-042 error high in CLEAR -> GAMEOVER with game_over = 1; buttons have no effect; new_game pulse -> NEWBOARD with score = 0.
REQ-043 restart_n pulsed low mid-MOVE between clock edges -> outputs reach reset values immediately, before the next edge.
